// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: operation encodings, FSM states
// and the classifier that separates iterative ops from single-cycle ones.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MULU = 4'b1000;
    localparam logic [3:0] ALU_DIVU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] ctrl);
        return (ctrl == ALU_MULU) || (ctrl == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/result handshake bundle between the EX-stage controller (master)
// and the ALU (slave).
interface alu_iter_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] result_hi_o;
    logic             zero_o;
    logic             overflow_o;

    modport master (
        output valid_i, src1_i, src2_i, ctrl_i, ready_i,
        input  ready_o, valid_o, result_o, result_hi_o, zero_o, overflow_o
    );

    modport slave (
        input  valid_i, src1_i, src2_i, ctrl_i, ready_i,
        output ready_o, valid_o, result_o, result_hi_o, zero_o, overflow_o
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Shared iterative datapath: one shift-add multiply step or one restoring
// divide step per cycle. The {hi, lo} register pair is reused by both ops.
module alu_iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] step_lo,
    output logic [WIDTH-1:0] step_hi
);

    logic [WIDTH-1:0] hi_q, lo_q, opd_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   msum, trial, dsub;
    logic             dok;
    logic [WIDTH-1:0] nhi, nlo;

    assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign trial = {hi_q, lo_q[WIDTH-1]};
    assign dsub  = trial - {1'b0, opd_q};
    // Borrow out of the top bit means the trial subtract must be undone.
    assign dok   = ~dsub[WIDTH];

    always_comb begin
        nhi = msum[WIDTH:1];
        nlo = {msum[0], lo_q[WIDTH-1:1]};
        if (div_q) begin
            nhi = dok ? dsub[WIDTH-1:0] : trial[WIDTH-1:0];
            nlo = {lo_q[WIDTH-2:0], dok};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opd_q <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= a;
            opd_q <= b;
            div_q <= is_div;
            cnt_q <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_q  <= nhi;
            lo_q  <= nlo;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // The final step's values are handed out combinationally so the result
    // lands in the output register on the same edge the counter hits zero.
    assign last    = (cnt_q == CNT_W'(1));
    assign step_lo = nlo;
    assign step_hi = nhi;

endmodule

// File: rtl/alu_iter.sv
// Registered ALU with valid/ready on both sides; single-cycle ops resolve in
// one cycle, MULU/DIVU iterate WIDTH cycles in alu_iter_muldiv.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_iter_if.slave  bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_t state, state_nxt;

    logic             accept, md_start, md_last;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] a, b, sum, diff, alu_res;
    logic [SH_W-1:0]  shamt;
    logic             alu_ovf;

    logic [WIDTH-1:0] res_q, hi_q;
    logic             zero_q, ovf_q;

    assign bus.ready_o = (state == ST_IDLE);
    assign bus.valid_o = (state == ST_DONE);
    assign accept      = bus.valid_i && bus.ready_o;
    assign md_start    = accept && is_multicycle(bus.ctrl_i);

    assign a     = bus.src1_i;
    assign b     = bus.src2_i;
    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ctrl_i)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_NOR: alu_res = ~(a | b);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: alu_res = a << shamt;
            ALU_SRL: alu_res = a >> shamt;
            ALU_SRA: alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .start   (md_start),
        .is_div  (bus.ctrl_i == ALU_DIVU),
        .a       (a),
        .b       (b),
        .last    (md_last),
        .step_lo (md_lo),
        .step_hi (md_hi)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_multicycle(bus.ctrl_i) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_last) state_nxt = ST_DONE;
            ST_DONE: if (bus.valid_o && bus.ready_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs only load on a completing op, so they hold through DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            res_q  <= '0;
            hi_q   <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept && !is_multicycle(bus.ctrl_i)) begin
            res_q  <= alu_res;
            hi_q   <= '0;
            zero_q <= (alu_res == '0);
            ovf_q  <= alu_ovf;
        end else if (state == ST_BUSY && md_last) begin
            res_q  <= md_lo;
            hi_q   <= md_hi;
            zero_q <= (md_lo == '0);
            ovf_q  <= 1'b0;
        end
    end

    assign bus.result_o    = res_q;
    assign bus.result_hi_o = hi_q;
    assign bus.zero_o      = zero_q;
    assign bus.overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at WIDTH=32.
module tb_alu_iter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_iter_if #(.WIDTH(32)) bus();

    alu_iter #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        bus.ctrl_i  = c;
        bus.src1_i  = x;
        bus.src2_i  = y;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    // Cycles from accept edge until valid_o is seen, bounded at 100.
    task automatic wait_valid(output int n, output int busy_ready);
        n = 1;
        busy_ready = 0;
        while (bus.valid_o !== 1'b1 && n < 100) begin
            if (bus.ready_o !== 1'b0) busy_ready++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume();
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.result_o !== 32'h0 ||
            bus.result_hi_o !== 32'h0 || bus.zero_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL reset: valid=%b ready=%b res=%h hi=%h z=%b ov=%b, want 0 1 0 0 0 0",
                     bus.valid_o, bus.ready_o, bus.result_o, bus.result_hi_o, bus.zero_o, bus.overflow_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        int n, br;
        send(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_valid(n, br);
        total++;
        if (n !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", n); end
        total++;
        if (bus.result_o !== 32'h8000_0000 || bus.overflow_o !== 1'b1 || bus.zero_o !== 1'b0 ||
            bus.result_hi_o !== 32'h0) begin
            bad++;
            $display("FAIL add_ovf: res=%h ov=%b z=%b hi=%h want 80000000 1 0 0",
                     bus.result_o, bus.overflow_o, bus.zero_o, bus.result_hi_o);
        end
        consume();
        send(ALU_SUB, 32'd5, 32'd5);
        wait_valid(n, br);
        total++;
        if (bus.result_o !== 32'h0 || bus.zero_o !== 1'b1 || bus.overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL sub_zero: res=%h z=%b ov=%b want 0 1 0", bus.result_o, bus.zero_o, bus.overflow_o);
        end
        consume();
    endtask

    task automatic test_single_ops();
        int n, br;
        send(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        wait_valid(n, br);
        total++;
        if (bus.result_o !== 32'h1) begin bad++; $display("FAIL slt: got %h want 1", bus.result_o); end
        consume();
        send(ALU_SRA, 32'h8000_0000, 32'd4);
        wait_valid(n, br);
        total++;
        if (bus.result_o !== 32'hF800_0000) begin bad++; $display("FAIL sra: got %h want f8000000", bus.result_o); end
        consume();
        send(ALU_SLL, 32'h1234_5678, 32'd33);
        wait_valid(n, br);
        total++;
        if (bus.result_o !== 32'h2468_ACF0) begin bad++; $display("FAIL sll_mask: got %h want 2468acf0", bus.result_o); end
        consume();
        send(4'b1111, 32'd5, 32'd5);
        wait_valid(n, br);
        total++;
        if (bus.result_o !== 32'h0 || bus.zero_o !== 1'b1 || bus.overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL unused_ctrl: res=%h z=%b ov=%b want 0 1 0", bus.result_o, bus.zero_o, bus.overflow_o);
        end
        consume();
    endtask

    task automatic test_mulu();
        int n, br;
        send(ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(n, br);
        total++;
        if (n !== 33 || br !== 0) begin
            bad++;
            $display("FAIL mulu_latency: got %0d (ready high %0d cycles) want 33 (0)", n, br);
        end
        total++;
        if (bus.result_hi_o !== 32'hFFFF_FFFE || bus.result_o !== 32'h0000_0001 || bus.zero_o !== 1'b0) begin
            bad++;
            $display("FAIL mulu_result: hi=%h lo=%h z=%b want fffffffe 00000001 0",
                     bus.result_hi_o, bus.result_o, bus.zero_o);
        end
        consume();
    endtask

    task automatic test_divu();
        int n, br;
        send(ALU_DIVU, 32'd100, 32'd7);
        wait_valid(n, br);
        total++;
        if (bus.result_o !== 32'd14 || bus.result_hi_o !== 32'd2) begin
            bad++;
            $display("FAIL divu: q=%0d r=%0d want 14 2", bus.result_o, bus.result_hi_o);
        end
        consume();
        send(ALU_DIVU, 32'd9, 32'd0);
        wait_valid(n, br);
        total++;
        if (n !== 33) begin bad++; $display("FAIL div0_latency: got %0d want 33", n); end
        total++;
        if (bus.result_o !== 32'hFFFF_FFFF || bus.result_hi_o !== 32'd9) begin
            bad++;
            $display("FAIL div0: q=%h r=%h want ffffffff 9", bus.result_o, bus.result_hi_o);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int n, br, unstable;
        logic [31:0] r0, h0;
        logic z0, o0;
        send(ALU_ADD, 32'd1, 32'd1);
        wait_valid(n, br);
        r0 = bus.result_o; h0 = bus.result_hi_o; z0 = bus.zero_o; o0 = bus.overflow_o;
        total++;
        if (r0 !== 32'd2) begin bad++; $display("FAIL bp_result: got %h want 2", r0); end
        unstable = 0;
        bus.ctrl_i = ALU_SUB; bus.src1_i = 32'd50; bus.src2_i = 32'd8; bus.valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.result_o !== r0 ||
                bus.result_hi_o !== h0 || bus.zero_o !== z0 || bus.overflow_o !== o0)
                unstable++;
        end
        bus.valid_i = 1'b0;
        total++;
        if (unstable !== 0) begin bad++; $display("FAIL bp_hold: %0d unstable cycles want 0", unstable); end
        consume();
        total++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ready=%b valid=%b want 1 0", bus.ready_o, bus.valid_o);
        end
        send(ALU_ADD, 32'd4, 32'd6);
        wait_valid(n, br);
        total++;
        if (n !== 1 || bus.result_o !== 32'd10) begin
            bad++;
            $display("FAIL bp_next_add: lat=%0d res=%0d want 1 10", n, bus.result_o);
        end
        consume();
    endtask

    task automatic test_reset_mid_mulu();
        int n, br;
        send(ALU_MULU, 32'd3, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.valid_o !== 1'b0 || bus.result_o !== 32'h0 || bus.result_hi_o !== 32'h0 ||
            bus.zero_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: valid=%b res=%h hi=%h z=%b ov=%b want all 0",
                     bus.valid_o, bus.result_o, bus.result_hi_o, bus.zero_o, bus.overflow_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ready: ready=%b valid=%b want 1 0", bus.ready_o, bus.valid_o);
        end
        send(ALU_ADD, 32'd2, 32'd3);
        wait_valid(n, br);
        total++;
        if (n !== 1 || bus.result_o !== 32'd5) begin
            bad++;
            $display("FAIL midreset_add: lat=%0d res=%0d want 1 5", n, bus.result_o);
        end
        consume();
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.ctrl_i  = '0;
        test_reset();
        test_add_sub();
        test_single_ops();
        test_mulu();
        test_divu();
        test_backpressure();
        test_reset_mid_mulu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised successor to the project's combinational ALU.
- Adds registered outputs, a valid/ready handshake on both sides, iterative unsigned multiply and divide, and an overflow flag.
- Sits in the EX stage of the multi-cycle CPU. The controller issues one operation and holds it until it is accepted, then waits for the result.

Parameters:
- WIDTH, 32: operand and result width. Legal values are 8 to 64.
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. Synchronous, active-low.
- valid_i  in  1  operation request
- ready_o  out  1  block can accept an operation
- src1_i  in  WIDTH  operand A (dividend or multiplicand)
- src2_i  in  WIDTH  operand B (divisor, multiplier, or shift amount)
- ctrl_i  in  4  operation select
- valid_o  out  1  result available
- ready_i  in  1  consumer accepts the result
- result_o  out  WIDTH  result, or low product, or quotient
- result_hi_o  out  WIDTH  high product or remainder; 0 for every other op
- zero_o  out  1  result_o == 0
- overflow_o  out  1  signed overflow (ADD/SUB only)

Behaviour:
- ctrl_i encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR
  - 0011 SLL, 0100 SRL, 0101 SRA: shift src1 by src2[$clog2(WIDTH)-1:0]
  - 1000 MULU: full 2*WIDTH product
  - 1001 DIVU: quotient and remainder
  - Any other code: result 0, zero_o=1, overflow 0.
- FSM states: IDLE, BUSY, DONE.
- ready_o = (state==IDLE). Accept = valid_i && ready_o. Operands and ctrl are latched on accept.
- IDLE, on accept of a single-cycle op:
  - Result is computed and registered; go to DONE.
  - valid_o rises on the cycle after accept (latency 1).
- IDLE, on accept of MULU/DIVU:
  - Load the datapath; counter = WIDTH; go to BUSY.
- BUSY:
  - One shift-add (MULU) or one restoring-subtract (DIVU) step per cycle. Counter decrements.
  - Counter reaching 0 moves to DONE. valid_o first asserts WIDTH+1 cycles after accept.
  - valid_i is ignored in BUSY.
- DONE:
  - valid_o=1. All outputs are held stable until ready_i.
  - valid_o && ready_i returns to IDLE. The next accept is possible the following cycle; there is no same-cycle overlap.
- ADD/SUB:
  - Wrap modulo 2^WIDTH.
  - overflow_o = operand signs are equal (src2 inverted for SUB) and the result sign differs from them.
- SLT: result = {WIDTH-1 zeros, signed(src1)<signed(src2)}.
- Shifts: the amount is masked to log2(WIDTH) bits. SRA replicates the MSB.
- DIVU by zero: quotient = all ones, remainder = src1. Takes the same WIDTH-cycle latency. No flag.
- zero_o and overflow_o are registered together with result_o. They are only meaningful while valid_o=1.
- Reset (rst_i=0 at a clk_i edge), in any state including mid-BUSY:
  - state=IDLE; valid_o=0; result_o, result_hi_o, zero_o, overflow_o = 0; counter=0.
  - ready_o=1 after reset deasserts. An in-flight operation is discarded.

Decomposition:
- Shared package alu_pkg holds:
  - ctrl encoding localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MULU, ALU_DIVU)
  - FSM state typedef
  - helper is_multicycle(ctrl)
- One sub-module, alu_iter_muldiv, holds the shared shift register, accumulator and counter for MULU/DIVU. It has start/done signals and no handshake of its own.
- Single-cycle ops are combinational logic in the top level, feeding the output register.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 -> valid_o one cycle after accept, result 0x80000000, overflow_o=1, zero_o=0. SUB 5-5 -> result 0, zero_o=1, overflow_o=0.
- SLT -1 vs 1 -> 1. SRA 0x80000000 by 4 -> 0xF8000000. SLL by 33 -> amount masked to 1, result src1<<1. Unused ctrl 1111 -> result 0, zero_o=1.
- MULU 0xFFFFFFFF*0xFFFFFFFF:
  - ready_o low for 32 cycles.
  - valid_o at accept+33.
  - result_hi_o=0xFFFFFFFE, result_o=0x00000001.
- DIVU 100/7 -> result_o=14, result_hi_o=2. DIVU 9/0 -> result_o=0xFFFFFFFF, result_hi_o=9, same 33-cycle latency.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> outputs stable, ready_o=0, new valid_i ignored. Raise ready_i -> ready_o=1 on the next cycle, and a following ADD is accepted.
- Assert rst_i=0 at cycle 10 of a MULU -> next edge gives valid_o=0, all outputs 0, ready_o=1 after release. The following ADD 2+3 returns 5.
